// File: rtl/lsu_pkg.sv
// Shared constants and state type for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [3:0] WE_B = 4'b0001;
   localparam logic [3:0] WE_H = 4'b0011;
   localparam logic [3:0] WE_W = 4'b1111;

   typedef enum logic [1:0] {IDLE, REQ, WB} lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication/strobes, load right-shift,
// and misaligned/illegal access detection.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [1:0]  load_offset,
   input  logic [31:0] rdata,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_we,
   output logic [3:0]  ld_we,
   output logic        ld_zext,
   output logic        bad,
   output logic [31:0] ld_data
);

   logic misaligned;
   logic illegal;

   always_comb begin
      st_wdata   = store_data;
      st_we      = '0;
      ld_we      = '0;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3)
         F3_LB, F3_LBU: begin
            st_wdata = {4{store_data[7:0]}};
            st_we    = WE_B << offset;
            ld_we    = WE_B;
         end
         F3_LH, F3_LHU: begin
            st_wdata   = {2{store_data[15:0]}};
            st_we      = WE_H << offset;
            ld_we      = WE_H;
            misaligned = offset[0];
         end
         F3_LW: begin
            st_we      = WE_W;
            ld_we      = WE_W;
            misaligned = |offset;
         end
         default: illegal = 1'b1;
      endcase
      // Stores have no unsigned variants.
      if (is_store && funct3[2]) illegal = 1'b1;
   end

   assign ld_zext = funct3[2];
   assign bad     = (is_load && is_store) || illegal || misaligned;
   assign ld_data = rdata >> {load_offset, 3'b000};

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control: single-outstanding dmem handshake and register-file writeback.
// Define LSU_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT_CYCLES cycles.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] base,
   input  logic [31:0] imm,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_in,
   output logic        dmem_req,
   output logic [3:0]  dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [4:0]  wb_rd,
   output logic [3:0]  wb_we,
   output logic        wb_sign,
   output logic [31:0] wb_data,
   output logic        err
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   lsu_state_e  state;
   logic [31:0] ea;
   logic        accept;
   logic [31:0] st_wdata;
   logic [3:0]  st_we;
   logic [3:0]  ld_we;
   logic        ld_zext;
   logic        bad;
   logic [31:0] ld_data;

   // Per-transaction context latched at accept.
   logic        load_q;
   logic [4:0]  rd_q;
   logic [3:0]  width_q;
   logic        zext_q;
   logic [1:0]  off_q;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt;
`endif

   assign ea       = base + imm;
   assign accept   = in_valid && (is_load || is_store);
   assign in_ready = (state == IDLE);

   lsu_align u_align (
      .is_load     (is_load),
      .is_store    (is_store),
      .funct3      (funct3),
      .offset      (ea[1:0]),
      .store_data  (store_data),
      .load_offset (off_q),
      .rdata       (dmem_rdata),
      .st_wdata    (st_wdata),
      .st_we       (st_we),
      .ld_we       (ld_we),
      .ld_zext     (ld_zext),
      .bad         (bad),
      .ld_data     (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= '0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_we      <= '0;
         wb_rd      <= '0;
         wb_sign    <= 1'b0;
         wb_data    <= '0;
         err        <= 1'b0;
         load_q     <= 1'b0;
         rd_q       <= '0;
         width_q    <= '0;
         zext_q     <= 1'b0;
         off_q      <= '0;
`ifdef LSU_TIMEOUT_EN
         cnt        <= '0;
`endif
      end else begin
         err   <= 1'b0;
         wb_we <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bad) begin
                     err <= 1'b1;
                  end else begin
                     state      <= REQ;
                     dmem_req   <= 1'b1;
                     dmem_addr  <= {ea[31:2], 2'b00};
                     dmem_we    <= is_store ? st_we : 4'b0000;
                     dmem_wdata <= is_store ? st_wdata : 32'h0;
                     load_q     <= is_load;
                     rd_q       <= rd_in;
                     width_q    <= ld_we;
                     zext_q     <= ld_zext;
                     off_q      <= ea[1:0];
`ifdef LSU_TIMEOUT_EN
                     cnt        <= '0;
`endif
                  end
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (load_q) begin
                     wb_we   <= width_q;
                     wb_rd   <= rd_q;
                     wb_sign <= zext_q;
                     wb_data <= ld_data;
                     state   <= WB;
                  end else begin
                     state <= IDLE;
                  end
               end
`ifdef LSU_TIMEOUT_EN
               else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                  dmem_req <= 1'b0;
                  err      <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            WB:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected dmem/writeback/err events,
// a monitor pops and compares them as the DUT presents them.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] base;
   logic [31:0] imm;
   logic [31:0] store_data;
   logic [4:0]  rd_in;
   logic        dmem_req;
   logic [3:0]  dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [4:0]  wb_rd;
   logic [3:0]  wb_we;
   logic        wb_sign;
   logic [31:0] wb_data;
   logic        err;

   lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .is_load    (is_load),
      .is_store   (is_store),
      .funct3     (funct3),
      .base       (base),
      .imm        (imm),
      .store_data (store_data),
      .rd_in      (rd_in),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .wb_rd      (wb_rd),
      .wb_we      (wb_we),
      .wb_sign    (wb_sign),
      .wb_data    (wb_data),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      bit          chk_wdata;
   } mem_t;

   typedef struct {
      logic [4:0]  rd;
      logic [3:0]  we;
      logic        sign;
      logic [31:0] data;
   } wb_t;

   mem_t mem_q[$];
   wb_t  wb_q[$];
   int   err_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic exp_mem(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input bit chk);
      mem_t m;
      m.addr = a; m.we = we; m.wdata = wd; m.chk_wdata = chk;
      mem_q.push_back(m);
   endtask

   task automatic exp_wb(input logic [4:0] rd, input logic [3:0] we, input logic sign,
                         input logic [31:0] d);
      wb_t w;
      w.rd = rd; w.we = we; w.sign = sign; w.data = d;
      wb_q.push_back(w);
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   logic req_prev = 1'b0;
   mem_t m_got;
   wb_t  w_got;
   always @(posedge clk) begin
      #1;
      if (dmem_req && !req_prev) begin
         check("dmem_req expected", (mem_q.size() > 0), 1);
         if (mem_q.size() > 0) begin
            m_got = mem_q.pop_front();
            check("dmem_addr", dmem_addr, m_got.addr);
            check("dmem_we", {28'h0, dmem_we}, {28'h0, m_got.we});
            if (m_got.chk_wdata) check("dmem_wdata", dmem_wdata, m_got.wdata);
         end
      end
      req_prev = dmem_req;
      if (wb_we != 4'b0000) begin
         check("wb expected", (wb_q.size() > 0), 1);
         if (wb_q.size() > 0) begin
            w_got = wb_q.pop_front();
            check("wb_rd", {27'h0, wb_rd}, {27'h0, w_got.rd});
            check("wb_we", {28'h0, wb_we}, {28'h0, w_got.we});
            check("wb_sign", {31'h0, wb_sign}, {31'h0, w_got.sign});
            check("wb_data", wb_data, w_got.data);
         end
      end
      if (err) begin
         check("err expected", (err_q.size() > 0), 1);
         if (err_q.size() > 0) void'(err_q.pop_front());
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " idle before issue"}, {31'h0, in_ready}, 1);
   endtask

   // Issue one request; lat = expected cycle (accept edge -> cycle 1) at which in_ready returns.
   task automatic issue(input string name, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] b, input logic [31:0] i, input logic [31:0] sd,
                        input logic [4:0] rd, input bit mem, input int ack_dly,
                        input logic [31:0] rdata, input int lat);
      int c;
      wait_idle(name);
      @(negedge clk);
      in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
      base = b; imm = i; store_data = sd; rd_in = rd;
      @(posedge clk); #1;
      in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      c = 1;
      if (mem) begin
         repeat (ack_dly) begin
            @(posedge clk); #1;
            c++;
         end
         dmem_ack = 1'b1; dmem_rdata = rdata;
         @(posedge clk); #1;
         c++;
         dmem_ack = 1'b0;
      end
      while (!in_ready && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      check({name, " turnaround"}, c, lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      base = '0; imm = '0; store_data = '0; rd_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset in_ready", {31'h0, in_ready}, 1);
      check("reset dmem_req", {31'h0, dmem_req}, 0);
      check("reset dmem_we", {28'h0, dmem_we}, 0);
      check("reset dmem_addr", dmem_addr, 0);
      check("reset dmem_wdata", dmem_wdata, 0);
      check("reset wb_we", {28'h0, wb_we}, 0);
      check("reset wb_rd", {27'h0, wb_rd}, 0);
      check("reset wb_sign", {31'h0, wb_sign}, 0);
      check("reset wb_data", wb_data, 0);
      check("reset err", {31'h0, err}, 0);

      // SB at offset 3, ack two cycles after req
      exp_mem(32'h100, 4'b1000, 32'hABABABAB, 1);
      issue("sb", 0, 1, 3'b000, 32'h100, 32'h3, 32'h000000AB, 5'd0, 1, 2, 32'h0, 4);
      // LBU at 0x102
      exp_mem(32'h100, 4'b0000, 32'h0, 0);
      exp_wb(5'd5, 4'b0001, 1'b1, 32'h000011F0);
      issue("lbu", 1, 0, 3'b100, 32'h100, 32'h2, 32'h0, 5'd5, 1, 1, 32'h11F02233, 4);
      // LH at 0x102, same-cycle ack
      exp_mem(32'h100, 4'b0000, 32'h0, 0);
      exp_wb(5'd7, 4'b0011, 1'b0, 32'h00008001);
      issue("lh", 1, 0, 3'b001, 32'h0FF, 32'h3, 32'h0, 5'd7, 1, 0, 32'h80010000, 3);
      // LW minimum turnaround
      exp_mem(32'h100, 4'b0000, 32'h0, 0);
      exp_wb(5'd9, 4'b1111, 1'b0, 32'hDEADBEEF);
      issue("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd9, 1, 0, 32'hDEADBEEF, 3);
      // SW with negative offset, minimum store turnaround
      exp_mem(32'h1FC, 4'b1111, 32'h12345678, 1);
      issue("sw", 0, 1, 3'b010, 32'h200, 32'hFFFFFFFC, 32'h12345678, 5'd0, 1, 0, 32'h0, 2);
      // SH in upper half
      exp_mem(32'h100, 4'b1100, 32'hBEEFBEEF, 1);
      issue("sh", 0, 1, 3'b001, 32'h100, 32'h2, 32'h0000BEEF, 5'd0, 1, 1, 32'h0, 3);
      // LB with address wrap to 0x1, rd=0 still writes back
      exp_mem(32'h0, 4'b0000, 32'h0, 0);
      exp_wb(5'd0, 4'b0001, 1'b0, 32'h00000080);
      issue("lb", 1, 0, 3'b000, 32'hFFFFFFFF, 32'h2, 32'h0, 5'd0, 1, 0, 32'h00008000, 3);
      // SB at offset 0
      exp_mem(32'h40, 4'b0001, 32'hC3C3C3C3, 1);
      issue("sb0", 0, 1, 3'b000, 32'h40, 32'h0, 32'h123456C3, 5'd0, 1, 0, 32'h0, 2);

      // Error cases: err pulse, no memory access, in_ready stays high
      err_q.push_back(1);
      issue("lw mis", 1, 0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd1, 0, 0, 32'h0, 1);
      err_q.push_back(1);
      issue("sh mis", 0, 1, 3'b001, 32'h100, 32'h3, 32'h0, 5'd1, 0, 0, 32'h0, 1);
      err_q.push_back(1);
      issue("ld f3=011", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd1, 0, 0, 32'h0, 1);
      err_q.push_back(1);
      issue("st f3=100", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 5'd1, 0, 0, 32'h0, 1);
      err_q.push_back(1);
      issue("ld+st", 1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1, 0, 0, 32'h0, 1);
      issue("no flags", 0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1, 0, 0, 32'h0, 1);

      // Reset during REQ, then a stray ack
      wait_idle("rst");
      exp_mem(32'h400, 4'b0000, 32'h0, 0);
      @(negedge clk);
      in_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; base = 32'h400; imm = 32'h0;
      rd_in = 5'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; is_load = 1'b0;
      check("rst req before reset", {31'h0, dmem_req}, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst dmem_req at reset edge", {31'h0, dmem_req}, 0);
      check("rst in_ready", {31'h0, in_ready}, 1);
      @(negedge clk);
      rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("stray ack in_ready", {31'h0, in_ready}, 1);
      check("stray ack dmem_req", {31'h0, dmem_req}, 0);

      // LHU after reset
      exp_mem(32'h300, 4'b0000, 32'h0, 0);
      exp_wb(5'd31, 4'b0011, 1'b1, 32'h0000ABCD);
      issue("lhu", 1, 0, 3'b101, 32'h300, 32'h2, 32'h0, 5'd31, 1, 0, 32'hABCD1234, 3);

`ifdef LSU_TIMEOUT_EN
      begin
         int n = 0;
         wait_idle("timeout");
         exp_mem(32'h500, 4'b0000, 32'h0, 0);
         err_q.push_back(1);
         @(negedge clk);
         in_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; base = 32'h500; imm = 32'h0;
         @(posedge clk); #1;
         in_valid = 1'b0; is_load = 1'b0;
         while (dmem_req && n < 50) begin
            n++;
            @(posedge clk); #1;
         end
         check("timeout req cycles", n, 4);
         check("timeout in_ready", {31'h0, in_ready}, 1);
      end
`endif

      repeat (4) @(posedge clk);
      #2;
      check("mem queue drained", mem_q.size(), 0);
      check("wb queue drained", wb_q.size(), 0);
      check("err queue drained", err_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting directly upstream of the register file write port. It accepts one decoded load/store at a time, performs the data-memory transaction over a req/ack handshake, and aligns store data into byte lanes. For loads it presents rd, byte-enable and the extension flag so the register file can write back. Single-outstanding, non-pipelined; the core stalls on in_ready=0.

Parameters:
TIMEOUT_CYCLES, 16, max cycles dmem_req may stay high without dmem_ack (only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  request valid
in_ready  output  1  high only in IDLE
is_load  input  1  load operation
is_store  input  1  store operation
funct3  input  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
base  input  32  rs1 value
imm  input  32  sign-extended offset
store_data  input  32  rs2 value
rd_in  input  5  load destination
dmem_req  output  1  memory request, held until ack
dmem_we  output  4  byte-lane write strobes, 0000 for loads
dmem_addr  output  32  word-aligned address {ea[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  memory completion, one-cycle pulse
dmem_rdata  input  32  read word, valid when dmem_ack=1
wb_rd  output  5  writeback register index
wb_we  output  4  0001 byte, 0011 half, 1111 word, 0000 none
wb_sign  output  1  1 = zero-extend (LBU/LHU), 0 = sign-extend
wb_data  output  32  loaded data right-justified to bit 0
err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_we=0, wb_rd=0, wb_sign=0, wb_data=0, err=0. Reset mid-transaction drops dmem_req at that edge; a later stray dmem_ack is ignored in IDLE.
- States: IDLE, REQ, WB.
- IDLE: in_ready=1. Accept on in_valid=1 & (is_load|is_store). ea = base+imm, modulo 2^32. in_valid=1 with neither flag set: ignored, no err.
- Error check at accept: is_load&is_store; illegal funct3 (load 011/110/111, store anything other than 000/001/010); half access with ea[0]=1; word access with ea[1:0]!=0. On error: err=1 for the next cycle, no memory access, wb_we=0, stay IDLE.
- Legal accept -> REQ next cycle, with dmem_req=1 and dmem_addr/dmem_we/dmem_wdata registered and held stable until ack.
- Store lanes: SB wdata={4{byte}}, we=0001<<ea[1:0]; SH wdata={2{half}}, we=0011<<ea[1:0]; SW we=1111.
- REQ: on dmem_ack, dmem_req=0 at the next edge. A store -> IDLE. A load captures dmem_rdata>>(8*ea[1:0]) into wb_data, then goes to WB.
- WB: exactly one cycle. wb_we = 0001/0011/1111 for B,BU/H,HU/W. wb_sign=1 for BU/HU. wb_rd=rd_in as latched at accept. Then IDLE. wb_we=0 in every other cycle. rd=0 still issues a writeback; the register file discards it.
- Minimum latency: load accept at cycle 0, req at cycle 1, ack at cycle 1 allowed, WB at cycle 2, in_ready again at cycle 3. A store with ack at cycle 1 returns to in_ready at cycle 2.

Optional Feature:
LSU_TIMEOUT_EN: when defined, a counter runs in REQ and clears on entry. If it reaches TIMEOUT_CYCLES without ack: dmem_req drops, err pulses once, no writeback, return to IDLE. Without the macro, REQ waits indefinitely and no counter exists.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU); byte-enable constants WE_B=0001, WE_H=0011, WE_W=1111; state enum {IDLE, REQ, WB}.
- One combinational sub-module, lsu_align: store lane replication and strobe generation, load right-shift by offset, and misalign/illegal detection. The FSM and registers stay in lsu_ctrl.

Test Plan:
- SB base=0x100 imm=3 store_data=0x000000AB, ack after 2 cycles -> dmem_addr=0x100, we=1000, wdata=0xABABABAB, no wb_we.
- LBU addr 0x102, rdata=0x11F0_2233 -> wb_data[7:0]=0xF0, wb_we=0001, wb_sign=1, wb_rd=rd_in for exactly one cycle.
- LH addr 0x102, rdata=0x8001_0000 -> wb_data[15:0]=0x8001, wb_we=0011, wb_sign=0. Also cover LW addr 0x100 with same-cycle ack -> minimum 3-cycle turnaround.
- LW addr 0x101 and SH addr 0x103 -> err pulse, dmem_req never asserts, in_ready stays 1.
- rst_n=0 during REQ, then a dmem_ack arrives after reset -> dmem_req=0 at the reset edge, no wb_we, state IDLE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> dmem_req drops and err pulses on the 4th REQ cycle, no writeback.
